// File: rtl/imem_spi_loader_if.sv
// Pad-side serial pins plus the instruction-RAM write bus and loader status.
// The loader takes the master modport; the RAM/core side takes the slave modport.
interface imem_spi_loader_if #(
  parameter int ADDR_W = 4
);
  logic              sclk_in;
  logic              mosi_in;
  logic              cs_n_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_cnt;

  modport master (
    input  sclk_in, mosi_in, cs_n_in,
    output wr_en, wr_addr, wr_data, cpu_hold, done, err, word_cnt
  );

  modport slave (
    output sclk_in, mosi_in, cs_n_in,
    input  wr_en, wr_addr, wr_data, cpu_hold, done, err, word_cnt
  );
endinterface

// File: rtl/imem_spi_loader.sv
// Serial program loader for the instruction RAM; holds the CPU until a frame loads cleanly.
// Define IMEM_LOADER_CKSUM_EN to require a trailing XOR checksum byte after the last word.
module imem_spi_loader #(
  parameter int         DEPTH_WORDS = 16,
  parameter int         ADDR_W      = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_LOAD    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_spi_loader_if.master bus
);

`ifdef IMEM_LOADER_CKSUM_EN
  localparam bit CKSUM_EN = 1'b1;
`else
  localparam bit CKSUM_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(DEPTH_WORDS - 1);

  typedef enum logic [2:0] {IDLE, CMD, HI, LO, FULL, DONE, ERR, CKS} state_t;

  state_t                   state, state_nx;
  logic [SYNC_STAGES-1:0]   sclk_sync, mosi_sync, cs_sync;
  logic                     sclk_d, cs_d;
  logic                     sclk_s, mosi_s, cs_s;
  logic                     sclk_rise, cs_fall, cs_rise;
  logic [7:0]               shreg;
  logic [2:0]               bit_cnt;
  logic [7:0]               byte_val;
  logic                     byte_done;
  logic                     frame_start, has_word;
  logic                     wr_go_p0, wr_en_p1;
  logic [ADDR_W-1:0]        wr_addr_q;
  logic [15:0]              wr_data_q;
  logic [ADDR_W:0]          word_cnt_q;
  logic [7:0]               cks_acc;

  // Stage: pad synchronisers and edge detectors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi_in};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n_in};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // Stage: byte assembly, MSB first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (cs_s) begin
      bit_cnt <= '0;
    end else if (sclk_rise) begin
      shreg   <= byte_val;
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign byte_val    = {shreg[6:0], mosi_s};
  assign byte_done   = sclk_rise && (bit_cnt == 3'd7);
  assign frame_start = cs_fall && (state == IDLE || state == DONE || state == ERR);
  // A write still in flight counts as a completed word for the boundary check.
  assign has_word    = (word_cnt_q != '0) || wr_go_p0 || wr_en_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (cs_fall) state_nx = CMD;
      CMD: begin
        if (cs_rise)        state_nx = ERR;
        else if (byte_done) state_nx = (byte_val == CMD_LOAD) ? HI : ERR;
      end
      HI: begin
        if (cs_rise)        state_nx = (!CKSUM_EN && has_word && bit_cnt == 3'd0) ? DONE : ERR;
        else if (byte_done) state_nx = LO;
      end
      LO: begin
        if (cs_rise)        state_nx = ERR;
        else if (byte_done) state_nx = (word_cnt_q != LAST_WORD) ? HI : (CKSUM_EN ? CKS : FULL);
      end
      CKS: begin
        if (cs_rise)        state_nx = ERR;
        else if (byte_done) state_nx = (byte_val == cks_acc) ? FULL : ERR;
      end
      FULL: if (cs_rise) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.done     = (state == DONE);
    bus.err      = (state == ERR);
    bus.cpu_hold = (state != DONE);
  end

  // Stage: word latch -> write strobe -> count update, one clk apart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_go_p0   <= 1'b0;
      wr_en_p1   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      word_cnt_q <= '0;
      cks_acc    <= '0;
    end else begin
      wr_go_p0 <= byte_done && (state == LO);
      wr_en_p1 <= wr_go_p0;
      if (wr_go_p0) wr_addr_q <= word_cnt_q[ADDR_W-1:0];
      if (byte_done && state == HI) begin
        wr_data_q[15:8] <= byte_val;
        cks_acc         <= cks_acc ^ byte_val;
      end
      if (byte_done && state == LO) begin
        wr_data_q[7:0] <= byte_val;
        cks_acc        <= cks_acc ^ byte_val;
      end
      if (frame_start) begin
        word_cnt_q <= '0;
        cks_acc    <= '0;
      end else if (wr_en_p1) begin
        word_cnt_q <= word_cnt_q + (ADDR_W+1)'(1);
      end
    end
  end

  assign bus.wr_en    = wr_en_p1;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.word_cnt = word_cnt_q;

endmodule
